// File: rtl/spi_master_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_gen2                                              |
// | Description : SPI master with all four modes, programmable SCLK divider,   |
// |               multiple chip selects and variable-length MSB-first frames.  |
// |               Optional macro SPI_LSB_FIRST_EN adds the lsb_first input.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master_gen2 #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = $clog2(DATA_W) + 1,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_system,
    input  logic              reset_system,
    input  logic              start_transfer,
    input  logic [DATA_W-1:0] data_inR,
    input  logic [CNT_W-1:0]  size_transfer,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_outR,
    input  logic              miso,
    output logic              mosi,
    output logic              clk_spi,
    output logic [NUM_CS-1:0] cs
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_clk_div;
    logic [CNT_W-1:0]  r_size;
    logic [CNT_W:0]    r_edge;
    logic              r_cpol;
    logic              r_cpha;
    logic [CS_W-1:0]   r_cs_sel;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_data_out;
    logic              r_mosi;
    logic              r_clk_spi;
`ifdef SPI_LSB_FIRST_EN
    logic              r_lsb;
    logic [CNT_W-1:0]  r_rx_idx;
`endif

    logic [CNT_W-1:0]  w_size;
    logic [CNT_W-1:0]  w_shift_amt;
    logic [CNT_W:0]    w_edge_max;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_load_rest;
    logic              w_load_bit;
    logic [DATA_W-1:0] w_tx_rest;
    logic              w_tx_bit;
    logic              w_accept;
    logic              w_tick;
    logic              w_edge_evt;
    logic              w_leading;
    logic              w_last_edge;
    logic              w_sample_evt;
    logic              w_drive_evt;

    assign w_size       = (size_transfer > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : size_transfer;
    assign w_accept     = (r_state == ST_IDLE) && start_transfer && (w_size != '0);
    assign w_tick       = (r_div == r_clk_div);
    assign w_edge_evt   = (r_state == ST_SHIFT) && w_tick;
    assign w_leading    = ~r_edge[0];
    assign w_edge_max   = {r_size, 1'b0} - (CNT_W+1)'(1);
    assign w_last_edge  = (r_edge == w_edge_max);
    assign w_sample_evt = w_edge_evt && (w_leading ^ r_cpha);
    // cpha=0 has its first bit loaded at acceptance, so the final trailing edge drives nothing
    assign w_drive_evt  = w_edge_evt &&
                          ((r_cpha && w_leading) || (!r_cpha && !w_leading && !w_last_edge));

    // Transmit word is pre-aligned so the first bit to send always sits at the shift head
    always_comb begin
        w_shift_amt = CNT_W'(DATA_W) - w_size;
        w_load      = data_inR << w_shift_amt;
        w_load_bit  = w_load[DATA_W-1];
        w_load_rest = w_load << 1;
        w_tx_bit    = r_tx[DATA_W-1];
        w_tx_rest   = r_tx << 1;
`ifdef SPI_LSB_FIRST_EN
        if (lsb_first) begin
            w_load      = data_inR;
            w_load_bit  = data_inR[0];
            w_load_rest = data_inR >> 1;
        end
        if (r_lsb) begin
            w_tx_bit  = r_tx[0];
            w_tx_rest = r_tx >> 1;
        end
`endif
    end

    always_ff @(posedge clk_system) begin
        if (reset_system) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        cs           = '1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                busy = 1'b1;
                if (w_tick) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_edge_evt && w_last_edge) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (w_tick) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (busy) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (r_cs_sel == CS_W'(i)) cs[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_system) begin
        if (reset_system) begin
            r_div      <= '0;
            r_clk_div  <= '0;
            r_size     <= '0;
            r_edge     <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs_sel   <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_mosi     <= 1'b0;
            r_clk_spi  <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            r_lsb      <= 1'b0;
            r_rx_idx   <= '0;
`endif
        end else begin
            if (busy) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
            end

            if (w_accept) begin
                r_clk_div <= clk_div;
                r_size    <= w_size;
                r_edge    <= '0;
                r_cpol    <= cpol;
                r_cpha    <= cpha;
                r_cs_sel  <= cs_sel;
                r_rx      <= '0;
                r_clk_spi <= cpol;
                r_mosi    <= cpha ? 1'b0 : w_load_bit;
                r_tx      <= cpha ? w_load : w_load_rest;
`ifdef SPI_LSB_FIRST_EN
                r_lsb     <= lsb_first;
                r_rx_idx  <= '0;
`endif
            end

            if (w_edge_evt) begin
                r_clk_spi <= ~r_clk_spi;
                r_edge    <= r_edge + (CNT_W+1)'(1);
            end

            if (w_drive_evt) begin
                r_mosi <= w_tx_bit;
                r_tx   <= w_tx_rest;
            end

            if (w_sample_evt) begin
`ifdef SPI_LSB_FIRST_EN
                if (r_lsb) begin
                    r_rx     <= r_rx | (DATA_W'(miso) << r_rx_idx);
                    r_rx_idx <= r_rx_idx + CNT_W'(1);
                end else begin
                    r_rx <= (r_rx << 1) | DATA_W'(miso);
                end
`else
                r_rx <= (r_rx << 1) | DATA_W'(miso);
`endif
            end

            if ((r_state == ST_HOLD) && w_tick) begin
                r_data_out <= r_rx;
                r_mosi     <= 1'b0;
                r_clk_spi  <= r_cpol;
            end
        end
    end

    assign data_outR = r_data_out;
    assign mosi      = r_mosi;
    assign clk_spi   = r_clk_spi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_gen2                                           |
// | Description : Randomised self-checking bench for spi_master_gen2 against a |
// |               cycle-timed behavioural model of the SPI frame.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master_gen2;

    localparam int DATA_W = 8;
    localparam int NUM_CS = 3;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 4;
    localparam int CS_W   = 2;
    localparam int HIST   = 8192;

    logic              clk_system = 1'b0;
    logic              reset_system;
    logic              start_transfer;
    logic [DATA_W-1:0] data_inR;
    logic [CNT_W-1:0]  size_transfer;
    logic [DIV_W-1:0]  clk_div;
    logic              cpol;
    logic              cpha;
    logic [CS_W-1:0]   cs_sel;
    logic              lsb_first;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_outR;
    logic              miso;
    logic              mosi;
    logic              clk_spi;
    logic [NUM_CS-1:0] cs;

    logic              miso_rand;
    int                miso_mode;

    always #5 clk_system = ~clk_system;

    assign miso = (miso_mode == 1) ? mosi : (miso_mode == 2) ? 1'b1 : miso_rand;

    spi_master_gen2 #(
        .DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W), .CNT_W(CNT_W), .CS_W(CS_W)
    ) u_dut (
        .clk_system    (clk_system),
        .reset_system  (reset_system),
        .start_transfer(start_transfer),
        .data_inR      (data_inR),
        .size_transfer (size_transfer),
        .clk_div       (clk_div),
        .cpol          (cpol),
        .cpha          (cpha),
        .cs_sel        (cs_sel),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first     (lsb_first),
`endif
        .busy          (busy),
        .done          (done),
        .data_outR     (data_outR),
        .miso          (miso),
        .mosi          (mosi),
        .clk_spi       (clk_spi),
        .cs            (cs)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of the transfer in flight, anchored on its acceptance cycle
    bit          t_valid = 0;
    int          t_N, t_T, t_s, t_cs;
    bit          t_cpol, t_cpha, t_lsb;
    logic [7:0]  t_data;
    logic [7:0]  m_dout = 8'h00;
    bit          idle_cpol = 0;
    logic        miso_hist [HIST];

    int          done_cnt = 0;
    int          edge_cnt = 0;
    int          last_done_d = 0;
    int          last_edges = 0;
    logic        prev_clk = 1'b0;
    logic [7:0]  mosi_seq = 8'h00;

    always @(posedge clk_system) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic tx_bit(input int i);
        return t_lsb ? t_data[i] : t_data[t_s-1-i];
    endfunction

    always @(negedge clk_system) begin : p_cmp
        int d, dd, e, k, idx;
        logic [NUM_CS-1:0] ecs;
        logic [DATA_W-1:0] erx;
        if (done === 1'b1) done_cnt++;
        if (clk_spi !== prev_clk) edge_cnt++;
        prev_clk = clk_spi;
        d = cyc - t_N;
        if (!t_valid || d == 0) begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_cs", cs, 3'b111);
            chk("idle_mosi", mosi, 0);
            chk("idle_sclk", clk_spi, idle_cpol);
            chk("idle_dout", data_outR, m_dout);
        end else begin
            dd = 1 + t_T * (2 * t_s + 2);
            if (d < HIST) miso_hist[d] = miso;
            if (d < dd) begin
                ecs = '1;
                if (t_cs < NUM_CS) ecs[t_cs] = 1'b0;
                chk("xfer_busy", busy, 1);
                chk("xfer_done", done, 0);
                chk("xfer_cs", cs, ecs);
                e = (d >= 1 + 2 * t_T) ? (d - 1 - t_T) / t_T : 0;
                if (e > 2 * t_s) e = 2 * t_s;
                chk("xfer_sclk", clk_spi, t_cpol ^ e[0]);
                if (!t_cpha && d <= t_T) chk("setup_mosi", mosi, tx_bit(0));
                if (d >= 2 * t_T && d % t_T == 0) begin
                    k = d / t_T - 1;
                    if (k <= 2 * t_s && (k % 2) == (t_cpha ? 0 : 1)) begin
                        chk("sample_mosi", mosi, tx_bit(t_cpha ? k / 2 - 1 : (k - 1) / 2));
                        mosi_seq = {mosi_seq[6:0], mosi};
                    end
                end
            end else begin
                erx = '0;
                for (int i = 0; i < t_s; i++) begin
                    k = t_cpha ? 2 * i + 2 : 2 * i + 1;
                    idx = t_T + k * t_T;
                    if (t_lsb) erx[i] = miso_hist[idx];
                    else       erx[t_s-1-i] = miso_hist[idx];
                end
                chk("fin_busy", busy, 0);
                chk("fin_done", done, 1);
                chk("fin_cs", cs, 3'b111);
                chk("fin_mosi", mosi, 0);
                chk("fin_sclk", clk_spi, t_cpol);
                chk("fin_dout", data_outR, erx);
                m_dout      = erx;
                idle_cpol   = t_cpol;
                last_done_d = d;
                last_edges  = edge_cnt;
                t_valid     = 0;
            end
        end
    end

    task automatic start_xfer(input logic [7:0] d, input int sz, input int dv, input bit pol,
                              input bit pha, input int sel, input bit lsb, input int mm);
        @(posedge clk_system); #1;
        data_inR       = d;
        size_transfer  = CNT_W'(sz);
        clk_div        = DIV_W'(dv);
        cpol           = pol;
        cpha           = pha;
        cs_sel         = CS_W'(sel);
        lsb_first      = lsb;
        miso_mode      = mm;
        start_transfer = 1'b1;
        if (sz != 0) begin
            t_valid  = 1;
            t_N      = cyc;
            t_T      = dv + 1;
            t_s      = (sz > DATA_W) ? DATA_W : sz;
            t_cpol   = pol;
            t_cpha   = pha;
            t_cs     = sel;
            t_data   = d;
`ifdef SPI_LSB_FIRST_EN
            t_lsb    = lsb;
`else
            t_lsb    = 0;
`endif
            edge_cnt = 0;
            mosi_seq = 8'h00;
        end
        @(posedge clk_system); #1;
        start_transfer = 1'b0;
        data_inR       = DATA_W'($urandom);
        size_transfer  = CNT_W'($urandom);
        clk_div        = DIV_W'($urandom);
        cpol           = 1'($urandom);
        cpha           = 1'($urandom);
        cs_sel         = CS_W'($urandom);
        lsb_first      = 1'($urandom);
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && t_valid; i++) @(negedge clk_system);
        if (t_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_done: transfer still open after %0d cycles", maxc);
            t_valid = 0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_system); #1;
        start_transfer = 1'b1;
        size_transfer  = CNT_W'(3);
        data_inR       = 8'hFF;
        cs_sel         = CS_W'(0);
        @(posedge clk_system); #1;
        start_transfer = 1'b0;
    endtask

    initial begin
        miso_rand = 1'b0;
        forever begin
            @(posedge clk_system); #1;
            miso_rand = 1'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset_system   = 1'b1;
        start_transfer = 1'b0;
        data_inR       = '0;
        size_transfer  = '0;
        clk_div        = '0;
        cpol           = 1'b0;
        cpha           = 1'b0;
        cs_sel         = '0;
        lsb_first      = 1'b0;
        miso_mode      = 0;
        repeat (3) @(posedge clk_system);
        #1 reset_system = 1'b0;
        @(negedge clk_system);
        chk("reset_cs", cs, 3'b111);
        chk("reset_sclk", clk_spi, 0);

        // Mode 0, T=2, 0xA5 looped back
        start_xfer(8'hA5, 8, 1, 0, 0, 0, 0, 1);
        @(negedge clk_system);
        chk("t1_cs_n1", cs, 3'b110);
        wait_done(200);
        chk("t1_done_lat", last_done_d, 37);
        chk("t1_dout", data_outR, 8'hA5);
        chk("t1_edges", last_edges, 16);
        chk("t1_sclk_idle", clk_spi, 0);

        // Mode 3, T=1, miso held high
        start_xfer(8'h0C, 4, 0, 1, 1, 1, 0, 2);
        wait_done(100);
        chk("t2_done_lat", last_done_d, 11);
        chk("t2_dout", data_outR, 8'h0F);
        chk("t2_mosi_seq", mosi_seq[3:0], 4'b1100);
        chk("t2_sclk_idle", clk_spi, 1);

        // Reset in the middle of SHIFT abandons the frame
        start_xfer(8'h5A, 8, 2, 0, 0, 0, 0, 0);
        repeat (12) @(posedge clk_system);
        #1 reset_system = 1'b1;
        dc = done_cnt;
        @(posedge clk_system); #1;
        reset_system = 1'b0;
        t_valid   = 0;
        m_dout    = 8'h00;
        idle_cpol = 0;
        @(negedge clk_system);
        chk("rst_cs", cs, 3'b111);
        chk("rst_sclk", clk_spi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", data_outR, 8'h00);
        repeat (40) @(negedge clk_system);
        chk("rst_no_done", done_cnt, dc);
        start_xfer(8'h3C, 8, 0, 0, 1, 0, 0, 1);
        wait_done(100);
        chk("rst_after_dout", data_outR, 8'h3C);

        // cs_sel=2 with a second start pulse during the frame
        dc = done_cnt;
        start_xfer(8'h96, 6, 1, 1, 0, 2, 0, 0);
        repeat (5) @(posedge clk_system);
        @(negedge clk_system);
        chk("t3_cs_mid", cs, 3'b011);
        pulse_start();
        wait_done(200);
        repeat (5) @(negedge clk_system);
        chk("t3_single_done", done_cnt - dc, 1);
        chk("t3_cs_after", cs, 3'b111);

        // Size 0 is a no-op
        dc = done_cnt;
        start_xfer(8'hFF, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_busy", busy, 0);
        repeat (4) @(negedge clk_system);
        chk("t4_no_done", done_cnt, dc);

        // Size 12 clamps to 8
        start_xfer(8'hC3, 12, 0, 0, 0, 0, 0, 1);
        wait_done(100);
        chk("t5_done_lat", last_done_d, 19);
        chk("t5_dout", data_outR, 8'hC3);

        // cs_sel out of range: no cs asserted, done still pulses
        dc = done_cnt;
        start_xfer(8'h21, 3, 0, 0, 1, 3, 0, 0);
        @(negedge clk_system);
        chk("t6_cs_none", cs, 3'b111);
        wait_done(100);
        chk("t6_done", done_cnt - dc, 1);

        // Largest divider, single bit
        start_xfer(8'h01, 1, 255, 0, 0, 0, 0, 1);
        wait_done(2000);
        chk("t7_done_lat", last_done_d, 1025);
        chk("t7_dout", data_outR, 8'h01);

        // Start during FINISH is ignored; next IDLE cycle accepts
        start_xfer(8'h02, 2, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 50 && (cyc - t_N) != 7; i++) begin
            @(posedge clk_system); #1;
        end
        start_transfer = 1'b1;
        size_transfer  = CNT_W'(5);
        @(posedge clk_system); #1;
        start_transfer = 1'b0;
        @(negedge clk_system);
        chk("t8_fin_start_ignored", busy, 0);
        start_xfer(8'hE7, 8, 0, 1, 0, 1, 0, 1);
        wait_done(100);
        chk("t8_dout", data_outR, 8'hE7);

`ifdef SPI_LSB_FIRST_EN
        start_xfer(8'h01, 8, 1, 0, 0, 0, 1, 1);
        wait_done(200);
        chk("lsb_dout", data_outR, 8'h01);
        chk("lsb_first_bit", mosi_seq, 8'b1000_0000);
`endif

        // Randomised frames
        for (int n = 0; n < 24; n++) begin
            int sz, dv;
            sz = $urandom_range(0, 15);
            dv = $urandom_range(0, 4);
            start_xfer(8'($urandom), sz, dv, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 1));
            if (sz != 0) wait_done(200);
            repeat ($urandom_range(0, 3)) @(negedge clk_system);
        end

        repeat (4) @(negedge clk_system);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_gen2.md
Name: spi_master_gen2

Overview:
Parametrised second-generation SPI master. It supports all four SPI modes (CPOL/CPHA), a programmable SCLK divider, multiple chip selects and variable-length transfers up to DATA_W bits. It uses a busy/done handshake toward the system side. The block sits between system-side control logic and external SPI peripherals (sensors, keypad/LCD controllers) in the alarm design.

Parameters:
DATA_W, 8, maximum transfer length in bits and width of the data registers
NUM_CS, 1, number of chip-select outputs (one active per transfer)
DIV_W, 8, width of the clock-divider input
CNT_W, $clog2(DATA_W)+1, width of size_transfer (holds the value DATA_W)

Ports:
clk_system  input  1  system clock; the only clock in the block
reset_system  input  1  synchronous, active-high reset
start_transfer  input  1  request; accepted only while in IDLE
data_inR  input  DATA_W  transmit word; bits [size-1:0] are sent
size_transfer  input  CNT_W  bits to transfer; 0 = no-op; values above DATA_W are clamped to DATA_W
clk_div  input  DIV_W  SCLK half-period = clk_div+1 system clocks
cpol  input  1  SCLK idle level
cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge
cs_sel  input  $clog2(NUM_CS) (min 1)  index of the chip select to assert
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when a transfer completes
data_outR  output  DATA_W  received word, right-aligned, upper bits zero
miso  input  1  serial data in
mosi  output  1  serial data out; 0 when not transferring (never tri-stated)
clk_spi  output  1  SCLK, a registered output (not gated from clk_system)
cs  output  NUM_CS  active-low chip selects

Behaviour:
- Reset, sampled on the clk_system edge when reset_system=1, sets:
  - state=IDLE, busy=0, done=0, data_outR=0, mosi=0
  - clk_spi=0, captured cpol=0, cs=all ones
  - This applies mid-transfer: the transfer is abandoned, no done pulse is issued, and data_outR is cleared.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> FINISH -> IDLE.
- Acceptance (IDLE, start_transfer=1, clamped size!=0 in cycle N):
  - data_inR, size, clk_div, cpol, cpha and cs_sel are captured; later input changes have no effect until the next acceptance.
  - In cycle N+1: busy=1 and cs[cs_sel]=0; all other cs bits stay 1.
- With start_transfer=1 and size 0 there is no state change, busy stays 0 and no done pulse is issued.
- start_transfer is ignored while busy=1, and in FINISH.
- Let T=clk_div+1.
- SETUP lasts T cycles with clk_spi=cpol.
  - For cpha=0, the first mosi bit is valid from cycle N+1.
- SHIFT produces 2*size SCLK edges, each T cycles apart; leading edges toggle away from cpol.
  - cpha=0: sample miso on each leading edge; drive the next mosi bit on each trailing edge.
  - cpha=1: drive mosi on each leading edge; sample on each trailing edge.
  - SHIFT ends after the last edge; clk_spi then equals cpol.
- HOLD lasts T cycles with cs still asserted.
- FINISH lasts one cycle: cs=all ones, busy=0, done=1, data_outR=received bits, mosi=0.
  - done therefore asserts in cycle N+1+T*(2*size+2).
- The earliest next acceptance is the IDLE cycle following FINISH.
- Bit order is MSB-first: data_inR[size-1] is sent first; the first bit received lands in data_outR[size-1].
- Divider counter and bit counter reload on every acceptance; no wrap-around or overflow occurs at clk_div = all ones (T=2^DIV_W).
- cs_sel >= NUM_CS: the transfer runs with no cs bit asserted; done is still issued.

Optional Feature:
SPI_LSB_FIRST_EN:
- Defined: adds input port lsb_first (1 bit), captured at acceptance. When lsb_first=1, data_inR[0] is sent first and the first received bit lands in data_outR[0]. The result remains right-aligned in [size-1:0].
- Undefined: the port is absent and the block is MSB-first only.

Test Plan:
- Mode 0, clk_div=1, size=8, data_inR=0xA5, miso looped to mosi, start at N -> cs=0 at N+1; done at N+37; data_outR=0xA5; 16 clk_spi edges; clk_spi idles at 0.
- Mode 3, clk_div=0, size=4, miso tied 1, data_inR=0x0C -> clk_spi idles 1; mosi sequence 1,1,0,0; data_outR=0x0F; done at N+11.
- NUM_CS=4, cs_sel=2 -> cs=4'b1011 during the transfer, 4'b1111 after; start_transfer pulsed again mid-transfer is ignored (a single done pulse).
- size_transfer=0 with start -> busy, cs and done unchanged; size_transfer=12 with DATA_W=8 -> 8 bits transferred.
- reset_system=1 during SHIFT -> next cycle cs=all ones, clk_spi=0, busy=0, data_outR=0, no done pulse; a fresh transfer then completes normally.
- SPI_LSB_FIRST_EN defined, lsb_first=1, data_inR=0x01, size=8, loopback -> mosi 1 sent first; data_outR=0x01.
